qam_symbol_scheduler: RTL and testbench
=======================================

Name: qam_symbol_scheduler

Overview:
Sequences the digital QAM modulator datapath. Buffers incoming bytes and splits each into two 4-bit 16-QAM symbol codes, high nibble first. Paces symbol release with a programmable symbol-rate divider and prepends a fixed preamble to every burst. Asserts the alignment pulse that marks the first data symbol for the downstream mapper.

Parameters:
DIV, 16, symbol period in clk cycles (must be >= 2)
FIFO_DEPTH, 4, byte FIFO depth (power of two, >= 2)
PRE_LEN, 4, preamble length in symbols (>= 1)
PRE_SYM, 4'b1010, symbol code emitted during preamble

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset; clears all state
en  input  1  burst enable; level-sensitive
in_data  input  8  byte to transmit
in_valid  input  1  in_data valid
in_ready  output  1  FIFO can accept a byte (= !full)
sym_stb  output  1  one-cycle strobe, new symbol on sym
sym  output  4  current symbol code, held between strobes
sym_valid  output  1  sym carries a preamble or data symbol
m_align  output  1  one-cycle pulse coincident with sym_stb of first data symbol of a burst
busy  output  1  FSM not in IDLE
underrun  output  1  one-cycle pulse: data symbol due, FIFO empty, en high

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, FIFO empty, divider=0, nibble select=high. Outputs: sym_stb=0, sym=0, sym_valid=0, m_align=0, busy=0, underrun=0. in_ready=1 once rst releases.
- FIFO: push when in_valid&in_ready. Pop only on the strobe that consumes a low nibble. Push and pop in the same cycle are both honoured. Push when full is impossible (in_ready=0). Pop when empty never occurs.
- Divider: counts 0..DIV-1 while busy, wraps to 0, and is held at 0 in IDLE. Tick = (count==DIV-1).
- All outputs are registered. sym_stb, sym and sym_valid update on the same edge.
- FSM:
  - IDLE: when en=1 and FIFO non-empty -> PREAMBLE, with divider cleared. The first strobe occurs DIV cycles after entry.
  - PREAMBLE: on each tick emit PRE_SYM with sym_valid=1. After PRE_LEN strobes -> DATA.
  - DATA: on each tick:
    - FIFO non-empty: emit the head byte's high nibble, then its low nibble on the next tick, then pop. m_align=1 on the first data strobe after PREAMBLE only.
    - Tick at a byte boundary, FIFO empty, en=1: emit sym=0, sym_valid=0, sym_stb=1, underrun=1. Remain in DATA.
    - Tick at a byte boundary, FIFO empty, en=0: -> IDLE with no strobe. sym_valid cleared; sym holds its last value.
    - en=0 with FIFO non-empty: continue until FIFO drains, then -> IDLE.
- A byte is never split: en falling between the two nibbles still emits the low nibble.
- en rising again in IDLE starts a fresh burst with a new preamble.
- Reset asserted mid-burst aborts immediately. Buffered bytes are discarded.

Optional Feature:
SCRAMBLER_EN. When defined, data nibbles (not preamble or underrun fills) are XORed with 4 bits from a 7-bit LFSR, x^7+x^6+1. The LFSR is seeded 7'h7F on entry to PREAMBLE and advances 4 steps per data strobe; the transmitted symbol uses the LFSR's low 4 bits before advance. When undefined, nibbles pass unmodified and no LFSR is built.

Test Plan:
- Reset check: drive rst=0 mid-burst -> all outputs 0 within the same cycle, FIFO empty; in_ready=1 after release.
- DIV=4, push 0xA5 then raise en -> strobes every 4 cycles: 1010 x4 (sym_valid=1), then 1010 with m_align=1, then 0101. With en then low -> busy falls; no further strobes.
- Push 0x3C and 0x81 back-to-back -> symbols 3,C,8,1 on consecutive strobes after preamble; m_align only with symbol 3.
- Backpressure: hold en=0 and push 5 bytes into FIFO_DEPTH=4 -> in_ready=0 after 4th push. The 5th byte is accepted only after the first pop once en is raised.
- Underrun: en=1, one byte 0xF0, no more input -> F, 0, then a strobe with sym_valid=0 and underrun=1. Push 0x12 -> 1, 2 follow with no new preamble and no m_align.
- With SCRAMBLER_EN: byte 0x00 -> first data symbol equals the seed's low nibble 0xF. Preamble symbols remain PRE_SYM.

Source files
------------

// File: rtl/qam_symbol_scheduler.sv
// QAM symbol scheduler: byte FIFO, nibble splitter, symbol-rate pacing, preamble and alignment pulse.
// Define SCRAMBLER_EN to XOR data nibbles with an x^7+x^6+1 LFSR.
module qam_symbol_scheduler #(
   parameter int          DIV        = 16,
   parameter int          FIFO_DEPTH = 4,
   parameter int          PRE_LEN    = 4,
   parameter logic [3:0]  PRE_SYM    = 4'b1010
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       sym_stb,
   output logic [3:0] sym,
   output logic       sym_valid,
   output logic       m_align,
   output logic       busy,
   output logic       underrun
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(DIV);
   localparam int PW = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;

   typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt;
   logic [PW-1:0]   pre_cnt, pre_cnt_nx;
   logic            nib_hi, nib_hi_nx;
   logic            first, first_nx;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr;
   logic            full, empty, push, pop, tick;
   logic [7:0]      head;
   logic [3:0]      dmask;
   logic            stb_nx, vld_nx, align_nx, und_nx;
   logic [3:0]      sym_nx;

   assign full     = (wr_ptr - rd_ptr) == (AW+1)'(FIFO_DEPTH);
   assign empty    = (wr_ptr == rd_ptr);
   assign in_ready = !full;
   assign push     = in_valid & in_ready;
   assign head     = mem[rd_ptr[AW-1:0]];
   assign tick     = (cnt == CW'(DIV-1));

   // FIFO storage carries no reset; emptiness is defined by the pointers alone
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= in_data;
   end

   always_comb begin
      state_nx   = state;
      pre_cnt_nx = pre_cnt;
      nib_hi_nx  = nib_hi;
      first_nx   = first;
      pop        = 1'b0;
      stb_nx     = 1'b0;
      align_nx   = 1'b0;
      und_nx     = 1'b0;
      sym_nx     = sym;
      vld_nx     = sym_valid;
      case (state)
         IDLE: begin
            if (en && !empty) begin
               state_nx   = PRE;
               pre_cnt_nx = '0;
               nib_hi_nx  = 1'b1;
            end
         end
         PRE: begin
            if (tick) begin
               stb_nx = 1'b1;
               sym_nx = PRE_SYM;
               vld_nx = 1'b1;
               if (pre_cnt == PW'(PRE_LEN-1)) begin
                  state_nx = DATA;
                  first_nx = 1'b1;
               end else begin
                  pre_cnt_nx = pre_cnt + PW'(1);
               end
            end
         end
         DATA: begin
            if (tick) begin
               // Low nibble always follows its high nibble, regardless of en
               if (!nib_hi) begin
                  stb_nx    = 1'b1;
                  sym_nx    = head[3:0] ^ dmask;
                  vld_nx    = 1'b1;
                  pop       = 1'b1;
                  nib_hi_nx = 1'b1;
               end else if (!empty) begin
                  stb_nx    = 1'b1;
                  sym_nx    = head[7:4] ^ dmask;
                  vld_nx    = 1'b1;
                  align_nx  = first;
                  first_nx  = 1'b0;
                  nib_hi_nx = 1'b0;
               end else if (en) begin
                  stb_nx = 1'b1;
                  sym_nx = 4'd0;
                  vld_nx = 1'b0;
                  und_nx = 1'b1;
               end else begin
                  state_nx = IDLE;
                  vld_nx   = 1'b0;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         pre_cnt   <= '0;
         nib_hi    <= 1'b1;
         first     <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         sym_stb   <= 1'b0;
         sym       <= 4'd0;
         sym_valid <= 1'b0;
         m_align   <= 1'b0;
         underrun  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
         pre_cnt   <= pre_cnt_nx;
         nib_hi    <= nib_hi_nx;
         first     <= first_nx;
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
         sym_stb   <= stb_nx;
         sym       <= sym_nx;
         sym_valid <= vld_nx;
         m_align   <= align_nx;
         underrun  <= und_nx;
         busy      <= (state_nx != IDLE);
      end
   end

`ifdef SCRAMBLER_EN
   logic [6:0] lfsr;

   function automatic logic [6:0] lfsr_step4(input logic [6:0] s);
      logic [6:0] r;
      r = s;
      for (int i = 0; i < 4; i++) r = {r[5:0], r[6] ^ r[5]};
      return r;
   endfunction

   assign dmask = lfsr[3:0];

   // Reseeded at every burst start; advances only on data-nibble strobes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         lfsr <= 7'h7F;
      else if (state == IDLE && state_nx == PRE)
         lfsr <= 7'h7F;
      else if (state == DATA && stb_nx && vld_nx)
         lfsr <= lfsr_step4(lfsr);
   end
`else
   assign dmask = 4'd0;
`endif

endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// Bench for qam_symbol_scheduler: byte table plus scoreboard of expected symbol strobes.
module tb_qam_symbol_scheduler;
   localparam int         DIV     = 4;
   localparam int         DEPTH   = 4;
   localparam int         PRE_LEN = 4;
   localparam logic [3:0] PRE_SYM = 4'b1010;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready, sym_stb, sym_valid, m_align, busy, underrun;
   logic [3:0] sym;

   qam_symbol_scheduler #(.DIV(DIV), .FIFO_DEPTH(DEPTH), .PRE_LEN(PRE_LEN), .PRE_SYM(PRE_SYM)) dut (
      .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sym_stb(sym_stb), .sym(sym), .sym_valid(sym_valid), .m_align(m_align), .busy(busy),
      .underrun(underrun)
   );

   always #5 clk = ~clk;

   typedef struct { logic [7:0] d; logic [3:0] hi; logic [3:0] lo; } vec_t;
   typedef struct { logic [3:0] s; logic v; logic a; logic u; } exp_t;

   vec_t tbl [10];
   exp_t sb [$];
   int   errors = 0;
   int   checks = 0;
   int   stb_cnt = 0;
   bit   mon_on = 1'b1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst && sym_stb) begin
         stb_cnt++;
         if (mon_on) begin
            if (sb.size() == 0) begin
               check("unexpected_strobe", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("sym", int'(sym), int'(e.s));
               check("sym_valid", int'(sym_valid), int'(e.v));
               check("m_align", int'(m_align), int'(e.a));
               check("underrun", int'(underrun), int'(e.u));
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_byte(input logic [7:0] d);
      int  n;
      logic acc;
      n = 0;
      in_data  = d;
      in_valid = 1'b1;
      do begin
         acc = in_ready;
         cyc(1);
         n++;
      end while (!acc && n < 200);
      in_valid = 1'b0;
      check("push_accept", int'(acc), 1);
   endtask

   task automatic exp_pre();
      for (int i = 0; i < PRE_LEN; i++) sb.push_back('{s: PRE_SYM, v: 1'b1, a: 1'b0, u: 1'b0});
   endtask

   task automatic exp_byte(input int idx, input logic align);
      sb.push_back('{s: tbl[idx].hi, v: 1'b1, a: align, u: 1'b0});
      sb.push_back('{s: tbl[idx].lo, v: 1'b1, a: 1'b0, u: 1'b0});
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         cyc(1);
         n++;
      end
      check("drain", sb.size(), 0);
      sb.delete();
   endtask

   task automatic wait_idle(input int budget);
      int n;
      int base;
      n = 0;
      while (busy && n < budget) begin
         cyc(1);
         n++;
      end
      check("busy_fall", int'(busy), 0);
      base = stb_cnt;
      cyc(4 * DIV);
      check("quiet_after_idle", stb_cnt - base, 0);
   endtask

   task automatic run_burst(input int first, input int n);
      for (int i = 0; i < n; i++) push_byte(tbl[first+i].d);
      exp_pre();
      for (int i = 0; i < n; i++) exp_byte(first + i, i == 0);
      en = 1'b1;
      cyc(1);
      en = 1'b0;
      wait_drain(400);
      wait_idle(50);
   endtask

   initial begin
      int base;
      logic acc;
      int n;
      tbl[0] = '{8'hA5, 4'hA, 4'h5};
      tbl[1] = '{8'h3C, 4'h3, 4'hC};
      tbl[2] = '{8'h81, 4'h8, 4'h1};
      tbl[3] = '{8'h00, 4'h0, 4'h0};
      tbl[4] = '{8'hFF, 4'hF, 4'hF};
      tbl[5] = '{8'h5A, 4'h5, 4'hA};
      tbl[6] = '{8'hC3, 4'hC, 4'h3};
      tbl[7] = '{8'h96, 4'h9, 4'h6};
      tbl[8] = '{8'hF0, 4'hF, 4'h0};
      tbl[9] = '{8'h12, 4'h1, 4'h2};

      #1 rst = 1'b0;
      cyc(3);
      check("rst_stb", int'(sym_stb), 0);
      check("rst_sym", int'(sym), 0);
      check("rst_valid", int'(sym_valid), 0);
      check("rst_busy", int'(busy), 0);
      rst = 1'b1;
      cyc(1);
      check("rst_in_ready", int'(in_ready), 1);

      run_burst(0, 1);
      check("hold_sym", int'(sym), 5);
      check("idle_valid", int'(sym_valid), 0);

      run_burst(1, 2);

      // Backpressure: fill the FIFO while idle, fifth byte waits for the first pop
      for (int i = 3; i < 6; i++) push_byte(tbl[i].d);
      check("bp_ready_3", int'(in_ready), 1);
      push_byte(tbl[6].d);
      check("bp_ready_full", int'(in_ready), 0);
      exp_pre();
      for (int i = 3; i < 8; i++) exp_byte(i, i == 3);
      base = stb_cnt;
      in_data  = tbl[7].d;
      in_valid = 1'b1;
      en       = 1'b1;
      n = 0;
      do begin
         acc = in_ready;
         cyc(1);
         n++;
      end while (!acc && n < 200);
      in_valid = 1'b0;
      en       = 1'b0;
      check("bp_accept", int'(acc), 1);
      check("bp_accept_after_pop", stb_cnt - base, PRE_LEN + 2);
      wait_drain(400);
      wait_idle(50);

      // Underrun then resume without a new preamble
      push_byte(tbl[8].d);
      exp_pre();
      exp_byte(8, 1'b1);
      sb.push_back('{s: 4'h0, v: 1'b0, a: 1'b0, u: 1'b1});
      en = 1'b1;
      wait_drain(200);
      exp_byte(9, 1'b0);
      push_byte(tbl[9].d);
      en = 1'b0;
      wait_drain(200);
      wait_idle(50);

      // Reset in the middle of a burst
      mon_on = 1'b0;
      push_byte(tbl[0].d);
      push_byte(tbl[1].d);
      en = 1'b1;
      cyc(4 * DIV + 3);
      check("mid_burst_valid", int'(sym_valid), 1);
      rst = 1'b0;
      #1;
      check("abort_stb", int'(sym_stb), 0);
      check("abort_sym", int'(sym), 0);
      check("abort_valid", int'(sym_valid), 0);
      check("abort_align", int'(m_align), 0);
      check("abort_underrun", int'(underrun), 0);
      check("abort_busy", int'(busy), 0);
      en = 1'b0;
      cyc(2);
      rst = 1'b1;
      cyc(1);
      check("post_rst_ready", int'(in_ready), 1);
      base = stb_cnt;
      en = 1'b1;
      cyc(3 * DIV);
      check("fifo_empty_no_start", int'(busy), 0);
      check("fifo_empty_no_stb", stb_cnt - base, 0);
      en = 1'b0;
      mon_on = 1'b1;
      cyc(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
